// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache / LSB arbiter in front of the byte-serial memory controller.
// Optional icache starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = 32'h0003_0000,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  io_buffer_full,
  input  logic                  flush,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_ack,
  output logic [31:0]           ic_data,
  input  logic                  lsb_req,
  input  logic                  lsb_is_load,
  input  logic [5:0]            lsb_opcode,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_ack,
  output logic [31:0]           lsb_rdata,
  output logic                  mc_req,
  output logic [1:0]            mc_kind,
  output logic [5:0]            mc_opcode,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [31:0]           mc_wdata,
  input  logic                  mc_done,
  input  logic [31:0]           mc_rdata
);

  localparam logic [1:0] KIND_FETCH = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state;
  logic   owner_lsb;
  logic   drop;
  logic   ic_ack_q;
  logic   lsb_ack_q;
  logic   lsb_io_blocked;
  logic   lsb_elig;
  logic   ic_elig;
  logic   grant_lsb;
  logic   grant_ic;
  logic   droppable;
  logic   drop_now;

  // Stores to I/O space wait while the UART cannot accept another byte.
  assign lsb_io_blocked = !lsb_is_load && (lsb_addr >= IO_ADDR_BASE) && io_buffer_full;
  assign lsb_elig       = lsb_req && !lsb_io_blocked;
  assign ic_elig        = ic_req && !flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;
  logic       ic_first;

  assign ic_first  = ic_elig && (int'(starve_cnt) >= STARVE_LIMIT);
  assign grant_ic  = ic_elig && (!lsb_elig || ic_first);
  assign grant_lsb = lsb_elig && !grant_ic;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (rdy && state == S_IDLE) begin
      if (!ic_req || grant_ic) begin
        starve_cnt <= 3'd0;
      end else if (grant_lsb && starve_cnt != 3'd7) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  assign grant_lsb = lsb_elig;
  assign grant_ic  = ic_elig && !lsb_elig;
`endif

  assign droppable = !owner_lsb || (mc_kind == KIND_LOAD);
  assign drop_now  = drop || (flush && droppable);

  // A flush landing in the response cycle still suppresses a speculative ack.
  assign ic_ack  = ic_ack_q && !(rdy && flush);
  assign lsb_ack = lsb_ack_q && !(rdy && flush && mc_kind == KIND_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_lsb <= 1'b0;
      drop      <= 1'b0;
      ic_ack_q  <= 1'b0;
      lsb_ack_q <= 1'b0;
      ic_data   <= 32'd0;
      lsb_rdata <= 32'd0;
      mc_req    <= 1'b0;
      mc_kind   <= KIND_FETCH;
      mc_opcode <= 6'd0;
      mc_addr   <= '0;
      mc_wdata  <= 32'd0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (grant_lsb) begin
            owner_lsb <= 1'b1;
            mc_kind   <= lsb_is_load ? KIND_LOAD : KIND_STORE;
            mc_opcode <= lsb_opcode;
            mc_addr   <= lsb_addr;
            mc_wdata  <= lsb_wdata;
            mc_req    <= 1'b1;
            state     <= S_ISSUE;
          end else if (grant_ic) begin
            owner_lsb <= 1'b0;
            mc_kind   <= KIND_FETCH;
            mc_opcode <= 6'd0;
            mc_addr   <= ic_addr;
            mc_wdata  <= 32'd0;
            mc_req    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mc_req <= 1'b0;
          drop   <= drop_now;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          drop <= drop_now;
          if (mc_done) begin
            if (owner_lsb) begin
              lsb_rdata <= mc_rdata;
            end else begin
              ic_data <= mc_rdata;
            end
            ic_ack_q  <= !owner_lsb && !drop_now;
            lsb_ack_q <= owner_lsb && !drop_now;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          ic_ack_q  <= 1'b0;
          lsb_ack_q <= 1'b0;
          drop      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a delayed memory-controller model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, flush;
  logic        ic_req, ic_ack;
  logic [31:0] ic_addr, ic_data;
  logic        lsb_req, lsb_is_load, lsb_ack;
  logic [5:0]  lsb_opcode;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        mc_req, mc_done;
  logic [1:0]  mc_kind;
  logic [5:0]  mc_opcode;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;

  localparam logic [5:0] OP_LW = 6'd2;
  localparam logic [5:0] OP_SB = 6'd5;
  localparam logic [5:0] OP_SW = 6'd7;

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mc_t;
  typedef struct {
    logic        who;
    logic [31:0] data;
  } rsp_t;

  mc_t  exp_mc[$];
  rsp_t exp_rsp[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, mc_cnt = 0, n_mc = 0;
  int req_cyc = 0, done_cyc = 0, lsb_ack_cyc = 0, gap = 0;
  logic [31:0] pend;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .flush(flush),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_is_load(lsb_is_load), .lsb_opcode(lsb_opcode),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_ack(lsb_ack), .lsb_rdata(lsb_rdata),
    .mc_req(mc_req), .mc_kind(mc_kind), .mc_opcode(mc_opcode), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h100) return 32'h00A0_0093;
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic push_cmd(input logic [1:0] k, input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
    mc_t e;
    e.kind = k; e.op = o; e.addr = a; e.wdata = w;
    exp_mc.push_back(e);
  endtask

  task automatic push_rsp(input logic who, input logic [31:0] d);
    rsp_t e;
    e.who = who; e.data = d;
    exp_rsp.push_back(e);
  endtask

  // Memory-controller model and monitor.
  always @(negedge clk) begin
    mc_t  em;
    rsp_t er;
    cyc++;
    mc_done = 1'b0;
    if (mc_cnt > 0) begin
      mc_cnt--;
      if (mc_cnt == 0) begin
        mc_done  = 1'b1;
        mc_rdata = pend;
        done_cyc = cyc;
      end
    end
    if (!rst) begin
      if (mc_req) begin
        n_mc++;
        gap     = cyc - done_cyc;
        req_cyc = cyc;
        mc_cnt  = 6;
        pend    = model(mc_addr);
        if (exp_mc.size() == 0) fail_now("mc_req_unexpected");
        else begin
          em = exp_mc.pop_front();
          check("mc_cmd", {24'b0, mc_kind, mc_opcode, mc_addr, mc_wdata},
                {24'b0, em.kind, em.op, em.addr, em.wdata});
        end
      end
      if (ic_ack) begin
        if (exp_rsp.size() == 0) fail_now("ic_ack_unexpected");
        else begin
          er = exp_rsp.pop_front();
          check("ic_rsp", {31'b0, 1'b0, 32'(cyc - done_cyc), ic_data}, {31'b0, er.who, 32'd1, er.data});
        end
      end
      if (lsb_ack) begin
        lsb_ack_cyc = cyc;
        if (exp_rsp.size() == 0) fail_now("lsb_ack_unexpected");
        else begin
          er = exp_rsp.pop_front();
          check("lsb_rsp", {31'b0, 1'b1, 32'(cyc - done_cyc), lsb_rdata}, {31'b0, er.who, 32'd1, er.data});
        end
      end
    end
  end

  // Requesters drop their level request in the ack cycle.
  task automatic step();
    @(negedge clk);
    #1;
    if (ic_ack) ic_req = 1'b0;
    if (lsb_ack) lsb_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp_mc.size() == 0 && exp_rsp.size() == 0 && !ic_req && !lsb_req && mc_cnt == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now(name);
    repeat (2) step();
  endtask

  task automatic wait_mc(input string name, input int n0);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (n_mc > n0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic chk_reset(input string name);
    check({name, "_rsp"}, {30'b0, ic_ack, ic_data, lsb_ack, lsb_rdata}, 96'd0);
    check({name, "_mc"}, {23'b0, mc_req, mc_kind, mc_opcode, mc_addr, mc_wdata}, 96'd0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t0, n0, rcyc;
    rst = 1; rdy = 1; io_buffer_full = 0; flush = 0;
    ic_req = 0; ic_addr = 0;
    lsb_req = 0; lsb_is_load = 0; lsb_opcode = 0; lsb_addr = 0; lsb_wdata = 0;
    mc_done = 0; mc_rdata = 0;
    repeat (3) step();
    chk_reset("reset");
    rst = 0;
    step();

    // 1: plain fetch
    push_cmd(2'd0, 6'd0, 32'h100, 32'd0);
    push_rsp(1'b0, 32'h00A0_0093);
    t0 = cyc;
    ic_addr = 32'h100; ic_req = 1;
    wait_done("t1_timeout");
    check("t1_grant_to_mc_req", 96'(req_cyc - t0), 96'd1);
    check("t1_ic_data_hold", 96'(ic_data), 96'h00A0_0093);

    // 2: simultaneous requests, LSB first then icache
    push_cmd(2'd1, OP_LW, 32'h2000, 32'd0);
    push_cmd(2'd0, 6'd0, 32'h108, 32'd0);
    push_rsp(1'b1, 32'h2000_BEEF);
    push_rsp(1'b0, 32'h0108_BEEF);
    lsb_is_load = 1; lsb_opcode = OP_LW; lsb_addr = 32'h2000; lsb_wdata = 0; lsb_req = 1;
    ic_addr = 32'h108; ic_req = 1;
    wait_done("t2_timeout");
    check("t2_ic_after_lsb_ack", 96'(req_cyc - lsb_ack_cyc), 96'd2);

    // 3: I/O store held while UART full
    push_cmd(2'd0, 6'd0, 32'h104, 32'd0);
    push_cmd(2'd2, OP_SB, 32'h3_0000, 32'h55);
    push_rsp(1'b0, 32'h0104_BEEF);
    push_rsp(1'b1, 32'h0000_BEEF);
    io_buffer_full = 1;
    lsb_is_load = 0; lsb_opcode = OP_SB; lsb_addr = 32'h3_0000; lsb_wdata = 32'h55; lsb_req = 1;
    ic_addr = 32'h104; ic_req = 1;
    for (int i = 0; i < 100 && ic_req; i++) step();
    n0 = n_mc;
    repeat (10) step();
    check("t3_store_held", 96'(n_mc), 96'(n0));
    io_buffer_full = 0;
    wait_done("t3_timeout");

    // 4a: flush during fetch WAIT drops the ack, icache redirected
    push_cmd(2'd0, 6'd0, 32'h200, 32'd0);
    push_cmd(2'd0, 6'd0, 32'h204, 32'd0);
    push_rsp(1'b0, 32'h0204_BEEF);
    n0 = n_mc;
    ic_addr = 32'h200; ic_req = 1;
    wait_mc("t4_fetch_issue", n0);
    repeat (2) step();
    flush_pulse();
    ic_addr = 32'h204;
    wait_done("t4_timeout");
    check("t4_regrant_gap", 96'(gap), 96'd3);

    // 4b: flush during store WAIT keeps the ack
    push_cmd(2'd2, OP_SW, 32'h3000, 32'hDEAD_BEEF);
    push_rsp(1'b1, 32'h3000_BEEF);
    n0 = n_mc;
    lsb_is_load = 0; lsb_opcode = OP_SW; lsb_addr = 32'h3000; lsb_wdata = 32'hDEAD_BEEF; lsb_req = 1;
    wait_mc("t4_store_issue", n0);
    repeat (2) step();
    flush_pulse();
    wait_done("t4b_timeout");
    check("t4_store_data", 96'(lsb_rdata), 96'h3000_BEEF);

    // 5: reset in WAIT, late mc_done is ignored
    push_cmd(2'd0, 6'd0, 32'h300, 32'd0);
    n0 = n_mc;
    ic_addr = 32'h300; ic_req = 1;
    wait_mc("t5_issue", n0);
    repeat (2) step();
    rst = 1; ic_req = 0;
    rcyc = cyc;
    step();
    chk_reset("t5_reset");
    rst = 0;
    repeat (10) step();
    check("t5_late_done_seen", 96'(done_cyc > rcyc), 96'd1);
    wait_done("t5_timeout");

    // 6: LSB held continuously with icache waiting
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      push_cmd(2'd1, OP_LW, 32'h4000 + 32'(4 * i), 32'd0);
      push_rsp(1'b1, {16'h4000 + 16'(4 * i), 16'hBEEF});
    end
    push_cmd(2'd0, 6'd0, 32'h10C, 32'd0);
    push_rsp(1'b0, 32'h010C_BEEF);
    push_cmd(2'd1, OP_LW, 32'h4010, 32'd0);
    push_rsp(1'b1, 32'h4010_BEEF);
`else
    for (int i = 0; i < 5; i++) begin
      push_cmd(2'd1, OP_LW, 32'h4000 + 32'(4 * i), 32'd0);
      push_rsp(1'b1, {16'h4000 + 16'(4 * i), 16'hBEEF});
    end
    push_cmd(2'd0, 6'd0, 32'h10C, 32'd0);
    push_rsp(1'b0, 32'h010C_BEEF);
`endif
    ic_addr = 32'h10C; ic_req = 1;
    lsb_is_load = 1; lsb_opcode = OP_LW; lsb_wdata = 0; lsb_addr = 32'h4000; lsb_req = 1;
    for (int i = 1; i < 5; i++) begin
      bit ok = 0;
      for (int j = 0; j < 100; j++) begin
        if (!lsb_req) begin
          ok = 1;
          break;
        end
        step();
      end
      if (!ok) fail_now("t6_lsb_timeout");
      lsb_addr = 32'h4000 + 32'(4 * i);
      lsb_req = 1;
    end
    wait_done("t6_timeout");

    check("queues_empty", 96'(exp_mc.size() + exp_rsp.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
